// File: rtl/shift_tap_accum.sv
// Fill/run controller for an external 8x64 tapped shift register.
// Sums the four taps once per accepted sample after the window is full.
module shift_tap_accum #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              shift,
    output logic [DATA_W-1:0] sr_in,
    input  logic [DATA_W-1:0] sr_tap_one,
    input  logic [DATA_W-1:0] sr_tap_two,
    input  logic [DATA_W-1:0] sr_tap_three,
    input  logic [DATA_W-1:0] sr_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W+1:0] out_sum,
    output logic [DATA_W-1:0] out_avg,
    output logic              primed
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  fill_cnt;
    logic [CNT_W-1:0]  fill_cnt_nxt;
    logic              pending;
    logic              pending_nxt;
    logic              load;
    logic [DATA_W+1:0] tap_sum;

    assign sr_in  = in_data;
    assign primed = (state == RUN);

    assign tap_sum = (DATA_W+2)'(sr_tap_one)
                   + (DATA_W+2)'(sr_tap_two)
                   + (DATA_W+2)'(sr_tap_three)
                   + (DATA_W+2)'(sr_out);

    always_comb begin
        in_ready     = 1'b0;
        state_nxt    = state;
        fill_cnt_nxt = fill_cnt;
        pending_nxt  = pending;
        if (rst_n) begin
            if (state == FILL) begin
                in_ready = 1'b1;
            end else begin
                in_ready = ~pending & (~out_valid | out_ready);
            end
        end
        shift = in_valid & in_ready & ~clear;
        load  = pending & (~out_valid | out_ready);
        if (clear) begin
            state_nxt    = FILL;
            fill_cnt_nxt = '0;
            pending_nxt  = 1'b0;
        end else begin
            if (load) begin
                pending_nxt = 1'b0;
            end
            if (shift) begin
                unique case (state)
                    FILL: begin
                        if (fill_cnt == CNT_W'(DEPTH - 1)) begin
                            state_nxt    = RUN;
                            fill_cnt_nxt = '0;
                            pending_nxt  = 1'b1;
                        end else begin
                            fill_cnt_nxt = fill_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        pending_nxt = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FILL;
            fill_cnt <= '0;
            pending  <= 1'b0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= fill_cnt_nxt;
            pending  <= pending_nxt;
        end
    end

    // Result registers hold across clear; only reset zeroes them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_avg   <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_sum   <= tap_sum;
            out_avg   <= tap_sum[DATA_W+1:2];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_tap_accum.sv
// Bench for shift_tap_accum: table vectors, directed corner
// sequences and random traffic against a sample-history model.
module tb_shift_tap_accum;

    localparam int DW = 8;
    localparam int DP = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          shift;
    logic [DW-1:0] sr_in;
    logic [DW-1:0] sr_tap_one;
    logic [DW-1:0] sr_tap_two;
    logic [DW-1:0] sr_tap_three;
    logic [DW-1:0] sr_out;
    logic          out_valid;
    logic          out_ready;
    logic [DW+1:0] out_sum;
    logic [DW-1:0] out_avg;
    logic          primed;

    always #5 clk = ~clk;

    shift_tap_accum #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear(clear),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .shift(shift),
        .sr_in(sr_in),
        .sr_tap_one(sr_tap_one),
        .sr_tap_two(sr_tap_two),
        .sr_tap_three(sr_tap_three),
        .sr_out(sr_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .out_avg(out_avg),
        .primed(primed)
    );

    // The attached shift register (not reset, starts at zero).
    logic [DW-1:0] sr [DP] = '{default: '0};

    always @(posedge clk) begin
        if (shift) begin
            for (int i = DP - 1; i > 0; i--) sr[i] <= sr[i-1];
            sr[0] <= sr_in;
        end
    end

    assign sr_tap_one   = sr[15];
    assign sr_tap_two   = sr[31];
    assign sr_tap_three = sr[47];
    assign sr_out       = sr[63];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: last DP accepted samples (newest at the back).
    logic [DW-1:0] hist [$];
    bit m_run, m_due, m_ov, e_shift;
    int m_fills, m_sum, m_avg;

    function automatic int tapsum();
        int s;
        s = 0;
        s += int'(hist[DP-1-15]);
        s += int'(hist[DP-1-31]);
        s += int'(hist[DP-1-47]);
        s += int'(hist[DP-1-63]);
        return s;
    endfunction

    task automatic apply(input bit iv, input logic [DW-1:0] id,
                         input bit ir, input bit ic, input bit irn);
        bit e_ready;
        rst_n     = irn;
        clear     = ic;
        in_valid  = iv;
        in_data   = id;
        out_ready = ir;
        #1;
        e_ready = irn && (!m_run || (!m_due && (!m_ov || ir)));
        e_shift = e_ready && iv && !ic;
        chk("in_ready", int'(in_ready), int'(e_ready));
        chk("shift", int'(shift), int'(e_shift));
        chk("sr_in", int'(sr_in), int'(id));
        chk("primed", int'(primed), int'(m_run));
        chk("out_valid", int'(out_valid), int'(m_ov));
        chk("out_sum", int'(out_sum), m_sum);
        chk("out_avg", int'(out_avg), m_avg);
    endtask

    task automatic advance();
        int ts;
        if (!rst_n) begin
            m_run = 0; m_due = 0; m_ov = 0;
            m_fills = 0; m_sum = 0; m_avg = 0;
        end else if (clear) begin
            m_run = 0; m_due = 0; m_ov = 0; m_fills = 0;
        end else begin
            if (m_due && (!m_ov || out_ready)) begin
                ts = tapsum();
                m_sum = ts;
                m_avg = ts / 4;
                m_ov = 1;
                m_due = 0;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
            if (e_shift) begin
                hist.push_back(in_data);
                void'(hist.pop_front());
                if (!m_run) begin
                    m_fills++;
                    if (m_fills == DP) begin
                        m_run = 1;
                        m_due = 1;
                    end
                end else begin
                    m_due = 1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input bit iv, input logic [DW-1:0] id,
                        input bit ir = 1, input bit ic = 0,
                        input bit irn = 1);
        apply(iv, id, ir, ic, irn);
        advance();
    endtask

    typedef struct {
        bit rn, c, v, r;
        logic [DW-1:0] d;
        bit e_rdy, e_sh, e_pr, e_ov;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{0, 0, 1, 1, 8'h00, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 1, 8'h00, 1, 0, 0, 0};
        tbl[2] = '{1, 1, 1, 1, 8'h33, 1, 0, 0, 0};
        tbl[3] = '{1, 0, 1, 1, 8'h5A, 1, 1, 0, 0};
        tbl[4] = '{1, 1, 1, 0, 8'h12, 1, 0, 0, 0};
        tbl[5] = '{0, 0, 1, 1, 8'h77, 0, 0, 0, 0};

        for (int i = 0; i < DP; i++) hist.push_back('0);
        m_run = 0; m_due = 0; m_ov = 0; e_shift = 0;
        m_fills = 0; m_sum = 0; m_avg = 0;

        // Unchecked first reset edge to leave the power-up X state.
        rst_n = 0; clear = 0; in_valid = 0; in_data = 0;
        out_ready = 1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);

        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c, tbl[i].rn);
            chk("tbl_ready", int'(in_ready), int'(tbl[i].e_rdy));
            chk("tbl_shift", int'(shift), int'(tbl[i].e_sh));
            chk("tbl_primed", int'(primed), int'(tbl[i].e_pr));
            chk("tbl_ovalid", int'(out_valid), int'(tbl[i].e_ov));
            advance();
        end

        // Fill with 1..64: first result 100 / 25.
        step(0, 0, 1, 0, 0);
        for (int i = 1; i <= DP; i++) begin
            step(1, DW'(i));
            chk("no_early_valid", int'(out_valid), 0);
        end
        chk("primed_after_fill", int'(primed), 1);
        step(0, 0);
        chk("first_valid", int'(out_valid), 1);
        chk("first_sum", int'(out_sum), 100);
        chk("first_avg", int'(out_avg), 25);

        // Push 65: result two cycles after accept.
        apply(1, 65, 1, 0, 1);
        chk("ready_65", int'(in_ready), 1);
        advance();
        chk("valid_gap_65", int'(out_valid), 0);
        step(0, 0);
        chk("sum_65", int'(out_sum), 104);
        chk("avg_65", int'(out_avg), 26);

        // Backpressure holds the result and blocks shifting.
        for (int i = 0; i < 3; i++) begin
            apply(1, 66, 0, 0, 1);
            chk("bp_ready", int'(in_ready), 0);
            chk("bp_shift", int'(shift), 0);
            advance();
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_sum", int'(out_sum), 104);
        end
        step(0, 0, 1);
        chk("bp_released", int'(out_valid), 0);
        apply(1, 66, 1, 0, 1);
        chk("bp_ready_back", int'(in_ready), 1);
        advance();
        step(0, 0);
        chk("sum_66", int'(out_sum), 108);

        // All 0xFF: no wrap in the sum.
        step(0, 0, 1, 1);
        for (int i = 0; i < DP; i++) step(1, 8'hFF);
        step(0, 0);
        chk("ff_valid", int'(out_valid), 1);
        chk("ff_sum", int'(out_sum), 1020);
        chk("ff_avg", int'(out_avg), 255);

        // Clear in RUN with in_valid high.
        apply(1, 8'h11, 1, 1, 1);
        chk("clr_shift", int'(shift), 0);
        advance();
        chk("clr_primed", int'(primed), 0);
        chk("clr_valid", int'(out_valid), 0);
        chk("clr_sum_hold", int'(out_sum), 1020);
        for (int i = 0; i < DP - 1; i++) begin
            step(1, 8'h11);
            chk("clr_no_result", int'(out_valid), 0);
        end
        step(1, 8'h11);
        step(0, 0);
        chk("clr_refill_valid", int'(out_valid), 1);
        chk("clr_refill_sum", int'(out_sum), 68);

        // Reset while a result is pending.
        step(1, 8'h22);
        apply(0, 0, 1, 0, 0);
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_shift", int'(shift), 0);
        advance();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_sum", int'(out_sum), 0);
        chk("rst_avg", int'(out_avg), 0);
        chk("rst_primed", int'(primed), 0);
        step(0, 0);
        chk("rst_no_result", int'(out_valid), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, DW'($urandom),
                 ($urandom % 3) != 0, ($urandom % 97) == 0,
                 ($urandom % 401) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
